// File: rtl/coeff_bank.sv
// rtl/coeff_bank.sv - double-buffered FIR coefficient store with tap sequencer
module coeff_bank #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              swap_req,
    output logic              swap_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              seq_start,
    output logic              seq_valid,
    output logic [WIDTH-1:0]  seq_data,
    output logic [ADDR_W-1:0] seq_idx,
    output logic              seq_last,
    output logic              seq_busy,
    output logic              act_valid
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {L_IDLE, L_FILL, L_FULL} lstate_t;

    lstate_t           lstate, lstate_n;
    logic [ADDR_W-1:0] wptr, wptr_n;
    logic [ADDR_W:0]   sh_ntaps, sh_ntaps_n;
    logic [ADDR_W:0]   act_ntaps;
    logic [ADDR_W:0]   act_last;
    logic              active;
    logic              swap_pend;
    logic              swap_go;
    logic              load_acc;
    logic              load_end;

    logic [WIDTH-1:0]  bank0 [DEPTH];
    logic [WIDTH-1:0]  bank1 [DEPTH];
    logic [ADDR_W-1:0] raddr;
    logic [WIDTH-1:0]  mem_q;
    logic              rd_zero;

    logic              seq_run;
    logic [ADDR_W-1:0] seq_cnt;
    logic              seq_at_end;
    logic              seq_go;

    assign load_ready = (lstate != L_FULL);
    assign load_acc   = load_valid & load_ready;
    assign load_end   = load_last | (wptr == ADDR_W'(DEPTH-1));

    // A request arriving in the very cycle the conditions hold swaps immediately.
    assign swap_go    = (swap_pend | swap_req) & (lstate == L_FULL) & ~seq_busy;

    // Busy covers the address-issue cycles plus the cycle the last tap is output.
    assign seq_busy   = seq_run | seq_valid;
    assign seq_go     = seq_start & ~seq_busy & act_valid & ~swap_go;
    assign act_last   = act_ntaps - (ADDR_W+1)'(1);
    assign seq_at_end = ({1'b0, seq_cnt} == act_last);

    assign raddr      = seq_run ? seq_cnt : rd_addr;
    assign rd_data    = (rd_valid & ~rd_zero) ? mem_q : '0;
    assign seq_data   = seq_valid ? mem_q : '0;

    always_comb begin
        lstate_n   = lstate;
        wptr_n     = wptr;
        sh_ntaps_n = sh_ntaps;
        case (lstate)
            L_IDLE, L_FILL: begin
                if (load_acc) begin
                    wptr_n = wptr + ADDR_W'(1);
                    if (load_end) begin
                        lstate_n   = L_FULL;
                        sh_ntaps_n = {1'b0, wptr} + (ADDR_W+1)'(1);
                    end else begin
                        lstate_n = L_FILL;
                    end
                end
            end
            L_FULL: begin
                if (swap_go) begin
                    lstate_n = L_IDLE;
                    wptr_n   = '0;
                end
            end
            default: lstate_n = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lstate   <= L_IDLE;
            wptr     <= '0;
            sh_ntaps <= '0;
        end else begin
            lstate   <= lstate_n;
            wptr     <= wptr_n;
            sh_ntaps <= sh_ntaps_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            act_valid <= 1'b0;
            act_ntaps <= '0;
            swap_pend <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= swap_go;
            if (swap_go) begin
                active    <= ~active;
                act_ntaps <= sh_ntaps;
                act_valid <= 1'b1;
                swap_pend <= 1'b0;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_run   <= 1'b0;
            seq_cnt   <= '0;
            seq_valid <= 1'b0;
            seq_idx   <= '0;
            seq_last  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_zero   <= 1'b0;
        end else begin
            if (seq_go) begin
                seq_run <= 1'b1;
                seq_cnt <= '0;
            end else if (seq_run) begin
                seq_cnt <= seq_cnt + ADDR_W'(1);
                if (seq_at_end) begin
                    seq_run <= 1'b0;
                end
            end
            seq_valid <= seq_run;
            seq_idx   <= seq_run ? seq_cnt : '0;
            seq_last  <= seq_run & seq_at_end;
            rd_valid  <= rd_en & ~seq_busy;
            rd_zero   <= ~act_valid | ({1'b0, rd_addr} >= act_ntaps);
        end
    end

    // Storage has no reset; one shared read port serves both sequencer and debug reads.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            if (active) begin
                bank0[wptr] <= load_data;
            end else begin
                bank1[wptr] <= load_data;
            end
        end
        mem_q <= active ? bank1[raddr] : bank0[raddr];
    end

endmodule

// File: tb/tb_coeff_bank.sv
// tb/tb_coeff_bank.sv - scoreboard bench for coeff_bank
module tb_coeff_bank;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_valid;
    logic [WIDTH-1:0]  load_data;
    logic              load_last;
    logic              load_ready;
    logic              swap_req;
    logic              swap_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              seq_start;
    logic              seq_valid;
    logic [WIDTH-1:0]  seq_data;
    logic [ADDR_W-1:0] seq_idx;
    logic              seq_last;
    logic              seq_busy;
    logic              act_valid;

    always #5 clk = ~clk;

    coeff_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .swap_req   (swap_req),
        .swap_done  (swap_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .seq_start  (seq_start),
        .seq_valid  (seq_valid),
        .seq_data   (seq_data),
        .seq_idx    (seq_idx),
        .seq_last   (seq_last),
        .seq_busy   (seq_busy),
        .act_valid  (act_valid)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH+ADDR_W:0] seq_q [$];
    logic [WIDTH-1:0]      rd_q [$];
    logic [WIDTH-1:0]      act_set [$];
    logic [WIDTH-1:0]      sh_set [$];
    logic [WIDTH+ADDR_W:0] seq_e;
    logic [WIDTH-1:0]      rd_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (seq_valid) begin
                if (seq_q.size() == 0) begin
                    chk("seq_unexpected", 1, 0);
                end else begin
                    seq_e = seq_q.pop_front();
                    chk("seq_data", 32'(seq_data), 32'(seq_e[WIDTH-1:0]));
                    chk("seq_idx", 32'(seq_idx), 32'(seq_e[WIDTH+ADDR_W-1:WIDTH]));
                    chk("seq_last", 32'(seq_last), 32'(seq_e[WIDTH+ADDR_W]));
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    rd_e = rd_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(rd_e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_set(input int n, input int base, input bit use_last);
        sh_set.delete();
        for (int i = 0; i < n; i++) begin
            chk("load_ready_fill", 32'(load_ready), 1);
            load_valid = 1'b1;
            load_data  = WIDTH'(base + i);
            load_last  = use_last && (i == n - 1);
            sh_set.push_back(WIDTH'(base + i));
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("load_ready_full", 32'(load_ready), 0);
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swap_done", 32'(swap_done), 1);
        chk("swap_ready", 32'(load_ready), 1);
        chk("swap_act_valid", 32'(act_valid), 1);
        act_set = sh_set;
        tick();
        chk("swap_done_pulse", 32'(swap_done), 0);
    endtask

    task automatic push_stream();
        int n = act_set.size();
        for (int i = 0; i < n; i++) begin
            seq_q.push_back({(i == n - 1), ADDR_W'(i), act_set[i]});
        end
    endtask

    task automatic stream();
        int n = act_set.size();
        push_stream();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        chk("seq_busy_start", 32'(seq_busy), 1);
        chk("seq_valid_latency", 32'(seq_valid), 0);
        repeat (n + 1) tick();
        chk("seq_busy_end", 32'(seq_busy), 0);
        chk("seq_q_empty", seq_q.size(), 0);
    endtask

    task automatic rd_check(input int addr, input int exp);
        rd_q.push_back(WIDTH'(exp));
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(addr);
        tick();
        rd_en = 1'b0;
        tick();
        chk("rd_q_empty", rd_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        swap_req   = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        seq_start  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        chk("rst_load_ready", 32'(load_ready), 1);
        chk("rst_act_valid", 32'(act_valid), 0);
        chk("rst_seq_valid", 32'(seq_valid), 0);
        chk("rst_seq_busy", 32'(seq_busy), 0);
        chk("rst_swap_done", 32'(swap_done), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_seq_last", 32'(seq_last), 0);
        chk("rst_seq_idx", 32'(seq_idx), 0);
        chk("rst_seq_data", 32'(seq_data), 0);
        chk("rst_rd_data", 32'(rd_data), 0);

        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        chk("empty_start_busy", 32'(seq_busy), 0);
        repeat (3) tick();
        rd_check(3, 0);

        load_set(16, 'h01, 1'b0);
        do_swap();
        stream();
        rd_check(15, 'h10);
        rd_check(0, 'h01);

        load_set(5, 'hA0, 1'b1);
        do_swap();
        stream();
        rd_check(7, 0);
        rd_check(4, 'hA4);
        rd_check(5, 0);

        // Swap deferred behind a running 16-tap stream
        load_set(16, 'h30, 1'b0);
        do_swap();
        push_stream();
        sh_set.delete();
        for (int k = 0; k < 6; k++) sh_set.push_back(WIDTH'('h60 + k));
        seq_start  = 1'b1;
        load_valid = 1'b1;
        load_data  = WIDTH'('h60);
        load_last  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("defer_busy", 32'(seq_busy), 32'(c <= 17));
            chk("defer_done", 32'(swap_done), 32'(c == 19));
            chk("defer_ready", 32'(load_ready), 32'(!(c >= 6 && c <= 18)));
            seq_start  = 1'b0;
            load_valid = (c <= 5);
            load_data  = WIDTH'('h60 + c);
            load_last  = (c == 5);
            swap_req   = (c == 7);
            rd_en      = (c == 10);
            rd_addr    = '0;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        swap_req   = 1'b0;
        rd_en      = 1'b0;
        chk("defer_q_empty", seq_q.size(), 0);
        act_set = sh_set;
        stream();

        // Backpressure: words offered while full must not be written
        load_set(16, 'hC0, 1'b0);
        load_valid = 1'b1;
        load_data  = WIDTH'('hEE);
        repeat (4) begin
            tick();
            chk("bp_ready", 32'(load_ready), 0);
        end
        load_valid = 1'b0;
        do_swap();
        stream();

        // Swap requested before the load completes
        sh_set.delete();
        for (int k = 0; k < 4; k++) sh_set.push_back(WIDTH'('hD0 + k));
        load_valid = 1'b1;
        load_data  = WIDTH'('hD0);
        load_last  = 1'b0;
        swap_req   = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("order_done", 32'(swap_done), 32'(c == 5));
            chk("order_ready", 32'(load_ready), 32'(c != 4));
            swap_req   = 1'b0;
            load_valid = (c <= 4);
            load_data  = (c <= 3) ? WIDTH'('hD0 + c) : WIDTH'('hEE);
            load_last  = (c == 3);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        act_set = sh_set;
        stream();

        // Reset in the middle of a stream
        push_stream();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        tick();
        tick();
        chk("pre_reset_valid", 32'(seq_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seq_valid", 32'(seq_valid), 0);
        chk("mid_rst_seq_busy", 32'(seq_busy), 0);
        chk("mid_rst_act_valid", 32'(act_valid), 0);
        chk("mid_rst_load_ready", 32'(load_ready), 1);
        seq_q.delete();
        rd_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        chk("post_rst_start_busy", 32'(seq_busy), 0);
        repeat (3) tick();
        rd_check(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coeff_bank.md
# coeff_bank

Parametrised, double-buffered coefficient store for the FIR datapath, replacing the fixed 16×8 coefficient ROM. Coefficients are streamed into a shadow bank while the active bank keeps serving the filter. A swap command makes the new set live atomically, and a built-in sequencer streams the active taps in order to the MAC stage. A random-access read port is retained for debug and legacy tap lookup.

## Interface
- `WIDTH`, 8, coefficient width in bits.
- `ADDR_W`, 4, tap address width; `DEPTH` = 2**`ADDR_W` taps per bank.

Ports:
- `clk` in 1: sole clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: load word offered.
- `load_data` in `WIDTH`: coefficient to load.
- `load_last` in 1: final coefficient of the set.
- `load_ready` out 1: shadow bank accepts a word.
- `swap_req` in 1: one-cycle pulse requesting a bank swap.
- `swap_done` out 1: one-cycle pulse when the swap executes.
- `rd_en` in 1: random read request.
- `rd_addr` in `ADDR_W`: random read tap address.
- `rd_data` out `WIDTH`: random read data.
- `rd_valid` out 1: `rd_data` is valid.
- `seq_start` in 1: start streaming the active set.
- `seq_valid` out 1: `seq_data` is valid.
- `seq_data` out `WIDTH`: streamed coefficient.
- `seq_idx` out `ADDR_W`: tap index of `seq_data`.
- `seq_last` out 1: final tap of the stream.
- `seq_busy` out 1: sequencer active.
- `act_valid` out 1: the active bank holds a loaded set.

## Operation
- Storage is two banks of `DEPTH`×`WIDTH` with synchronous read. Bank contents are not reset.
- The `active` bit selects the bank used for reads; the other bank is the shadow.
- Each bank has a tap count `ntaps` in the range 1..`DEPTH`.

Load FSM, states L_IDLE, L_FILL, L_FULL:
- `load_ready` = 1 in L_IDLE and L_FILL, and 0 in L_FULL.
- An accepted word (`load_valid`&`load_ready`) writes shadow[`wptr`] and increments `wptr`.
- L_IDLE moves to L_FILL on the first accepted word.
- An accepted word with `load_last`=1, or the word at `wptr`=`DEPTH`-1, moves the FSM to L_FULL and records shadow `ntaps`=`wptr`+1. This applies in L_IDLE too, so a single-word load goes straight to L_FULL.
- Words after a set is full are back-pressured.

Swap:
- `swap_req` sets `swap_pend`.
- The swap executes in the first cycle where `swap_pend`=1, the load FSM is in L_FULL and `seq_busy`=0. In that cycle:
  - `active` toggles.
  - The active `ntaps` takes the shadow count.
  - `act_valid` is set to 1.
  - The load FSM returns to L_IDLE with `wptr`=0.
  - `swap_pend` clears.
  - `swap_done` pulses the following cycle.
- A `swap_req` while one is already pending is absorbed; there is no queueing.

Sequencer:
- `seq_start` is accepted only when `seq_busy`=0 and `act_valid`=1; otherwise it is ignored.
- Once started, the sequencer reads taps 0..`ntaps`-1 of the active bank, one per cycle with no gaps. There is no backpressure.
- `seq_last` is asserted with tap `ntaps`-1.
- `seq_busy` is high from the cycle after start until the cycle `seq_last` is output.

Random read:
- A random read is served only when the sequencer is not issuing an address. `rd_en` during `seq_busy` is dropped, with no `rd_valid`.
- A read with `rd_addr` ≥ `ntaps` returns 0 with `rd_valid`=1.
- A read with `act_valid`=0 returns 0.

Reset:
- Load FSM in L_IDLE, `wptr`=0, `active`=0, `act_valid`=0, `swap_pend`=0.
- All outputs 0 except `load_ready`=1.
- Reset mid-load or mid-stream aborts the operation immediately.

## Timing
- Load: one word per cycle at full rate.
- `load_ready` falls the cycle after the terminating word is accepted.
- Swap: `swap_req` at cycle t, when the swap conditions already hold, gives `active` toggled at t+1 and `swap_done`=1 at t+1. `load_ready` returns to 1 at t+1.
- Random read: `rd_en` at t gives `rd_data`/`rd_valid` at t+1.
- Sequencer: `seq_start` at t gives the first `seq_valid` at t+2 and the last at t+1+`ntaps`. `seq_busy` = 1 from t+1 through t+1+`ntaps`.
- Swap during a stream: the swap waits and executes in the first cycle after `seq_busy` falls. Data in flight always comes from the pre-swap bank.
- Simultaneous `seq_start` and a swap execution in the same cycle: the swap wins and `seq_start` is ignored.

## Test plan
- **Reset, empty bank.** After reset, `load_ready`=1, `act_valid`=0 and all other outputs are 0. `seq_start` → no `seq_valid`. `rd_en`, addr 3 → `rd_data`=0, `rd_valid`=1.
- **Full load and stream.** Load 16 words 0x01..0x10 without `load_last`, then `swap_req`. Expect `load_ready`=0 after the 16th word and `swap_done` one cycle after the request. `seq_start` → 16 consecutive `seq_valid` with data 0x01..0x10 and `seq_last` on idx 15.
- **Short set.** Load 5 words 0xA0..0xA4 with `load_last` on the 5th, then swap and `seq_start`. Expect 5 outputs and `seq_last` at idx 4. `rd_addr`=7 → 0.
- **Swap deferred by stream.** With set A (16 taps) streaming, fill set B and pulse `swap_req` mid-stream. The stream completes with all A data, and `swap_done` pulses the cycle after `seq_busy` falls.
- **Backpressure and swap ordering.** Assert `load_valid` continuously through L_FULL: no writes occur. Pulse `swap_req` before the load completes: the swap executes exactly when L_FULL is reached.
- **Reset mid-stream.** Assert `rst_n`=0 during a stream: `seq_valid` and `seq_busy` drop immediately and `act_valid`=0.
